// File: rtl/bignum_operand_streamer_pkg.sv
// Shared definitions for the block-serial big-number operand streamer:
// default operand geometry and the streamer state encoding.
package bignum_operand_streamer_pkg;

    localparam int REGISTER_SIZE_DEFAULT = 32;
    localparam int BITS_IN_NUM_DEFAULT   = 4096;
    localparam int WORDS                 = BITS_IN_NUM_DEFAULT / REGISTER_SIZE_DEFAULT;
    localparam int ADDR_WIDTH            = $clog2(2 * WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_STREAM,
        ST_DRAIN
    } streamer_state_t;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-port read-first block RAM with an output register on each port
// (two-cycle read latency). Port A reads and writes, port B only reads.
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 256
) (
    input  logic                         clka,
    input  logic                         clkb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a_reg;
    logic [RAM_WIDTH-1:0] ram_data_b_reg;
    logic [RAM_WIDTH-1:0] douta_reg;
    logic [RAM_WIDTH-1:0] doutb_reg;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end
            ram_data_a_reg <= mem[addra];
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) begin
            ram_data_b_reg <= mem[addrb];
        end
    end

    // Output registers reset to zero; the array contents are never cleared.
    always_ff @(posedge clka) begin
        if (rsta) begin
            douta_reg <= '0;
        end else if (regcea) begin
            douta_reg <= ram_data_a_reg;
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            doutb_reg <= '0;
        end else if (regceb) begin
            doutb_reg <= ram_data_b_reg;
        end
    end

    assign douta = douta_reg;
    assign doutb = doutb_reg;

endmodule

// File: rtl/bignum_operand_streamer.sv
// Holds two big-number operands in BRAM and streams them out as a gapless
// burst of word pairs, least-significant word first, once the consumer is ready.
module bignum_operand_streamer
    import bignum_operand_streamer_pkg::*;
#(
    parameter  int REGISTER_SIZE = REGISTER_SIZE_DEFAULT,
    parameter  int BITS_IN_NUM   = BITS_IN_NUM_DEFAULT,
    localparam int N_WORDS       = BITS_IN_NUM / REGISTER_SIZE,
    localparam int AW            = $clog2(2 * N_WORDS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] load_data_in,
    input  logic [AW-1:0]            load_addr_in,
    input  logic                     load_valid_in,
    input  logic                     start_in,
    input  logic                     ready_in,
    output logic [REGISTER_SIZE-1:0] n_out,
    output logic [REGISTER_SIZE-1:0] m_out,
    output logic                     valid_out,
    output logic                     last_out,
    output logic                     busy_out,
    output logic                     done_out
);

    localparam int CW = $clog2(N_WORDS) + 1;

    streamer_state_t state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      valid_pipe_reg;
    logic [1:0]      last_pipe_reg;
    logic            done_reg, done_next;
    logic            issue_valid;
    logic            issue_last;

    logic [AW-1:0]            ram_addr_a;
    logic [AW-1:0]            ram_addr_b;
    logic                     ram_we;
    logic                     ram_regce;
    logic [REGISTER_SIZE-1:0] ram_dout_a;
    logic [REGISTER_SIZE-1:0] ram_dout_b;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            valid_pipe_reg <= '0;
            last_pipe_reg  <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            valid_pipe_reg <= {valid_pipe_reg[0], issue_valid};
            last_pipe_reg  <= {last_pipe_reg[0], issue_last};
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = '0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        done_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_in) begin
                    state_next = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (ready_in) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Consumer readiness is not rechecked: the burst never pauses.
                issue_valid = 1'b1;
                issue_last  = (cnt_reg == CW'(N_WORDS - 1));
                cnt_next    = cnt_reg + CW'(1);
                if (issue_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pipe_reg[1]) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ram_we     = load_valid_in && (state_reg == ST_IDLE);
        ram_regce  = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);
        ram_addr_a = (state_reg == ST_STREAM) ? AW'(cnt_reg) : load_addr_in;
        ram_addr_b = AW'(N_WORDS) + AW'(cnt_reg);
    end

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH (REGISTER_SIZE),
        .RAM_DEPTH (2 * N_WORDS)
    ) u_operand_ram (
        .clka   (clk_in),
        .clkb   (clk_in),
        .addra  (ram_addr_a),
        .addrb  (ram_addr_b),
        .dina   (load_data_in),
        .wea    (ram_we),
        .ena    (1'b1),
        .enb    (1'b1),
        .rsta   (rst_in),
        .rstb   (rst_in),
        .regcea (ram_regce),
        .regceb (ram_regce),
        .douta  (ram_dout_a),
        .doutb  (ram_dout_b)
    );

    assign valid_out = valid_pipe_reg[1];
    assign last_out  = last_pipe_reg[1];
    assign n_out     = valid_pipe_reg[1] ? ram_dout_a : '0;
    assign m_out     = valid_pipe_reg[1] ? ram_dout_b : '0;
    assign busy_out  = (state_reg != ST_IDLE);
    assign done_out  = done_reg;

endmodule

// File: tb/tb_bignum_operand_streamer.sv
// Directed bench for bignum_operand_streamer: table of expected word pairs,
// cycle-exact burst checks, mid-stream ignore, reset mid-burst, load+start.
module tb_bignum_operand_streamer;
    import bignum_operand_streamer_pkg::*;

    localparam int RS = REGISTER_SIZE_DEFAULT;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [RS-1:0]         load_data_in;
    logic [ADDR_WIDTH-1:0] load_addr_in;
    logic                  load_valid_in;
    logic                  start_in;
    logic                  ready_in;
    logic [RS-1:0]         n_out;
    logic [RS-1:0]         m_out;
    logic                  valid_out;
    logic                  last_out;
    logic                  busy_out;
    logic                  done_out;

    always #5 clk_in = ~clk_in;

    bignum_operand_streamer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_data_in  (load_data_in),
        .load_addr_in  (load_addr_in),
        .load_valid_in (load_valid_in),
        .start_in      (start_in),
        .ready_in      (ready_in),
        .n_out         (n_out),
        .m_out         (m_out),
        .valid_out     (valid_out),
        .last_out      (last_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    typedef struct {
        int            word;
        logic [RS-1:0] n_exp;
        logic [RS-1:0] m_exp;
        logic          last_exp;
    } word_vec_t;

    word_vec_t vecs [WORDS];
    int vec_count   = 0;
    int miscompares = 0;
    int xfer_id     = 0;

    task automatic check(input string name, input logic [RS-1:0] act, input logic [RS-1:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [RS-1:0] data);
        load_valid_in = 1'b1;
        load_addr_in  = ADDR_WIDTH'(addr);
        load_data_in  = data;
        tick();
        load_valid_in = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " n_out"}, n_out, '0);
        check({tag, " m_out"}, m_out, '0);
        check({tag, " valid_out"}, valid_out, 1'b0);
        check({tag, " last_out"}, last_out, 1'b0);
        check({tag, " busy_out"}, busy_out, 1'b0);
        check({tag, " done_out"}, done_out, 1'b0);
    endtask

    // k counts cycles after the start cycle S; ready rises at S+1+ready_low,
    // so word 0 is due at k = ready_low+4 and done one cycle after the last word.
    task automatic transfer(input int ready_low, input bit inject, input bit load_with_start);
        int first;
        int i;
        int bad_before;
        first      = ready_low + 4;
        bad_before = miscompares;
        start_in   = 1'b1;
        ready_in   = (ready_low == 0);
        if (load_with_start) begin
            load_valid_in = 1'b1;
            load_addr_in  = '0;
            load_data_in  = 32'h0000_1234;
            vecs[0].n_exp = 32'h0000_1234;
        end
        tick();
        start_in      = 1'b0;
        load_valid_in = 1'b0;
        for (int k = 1; k <= first + WORDS + 1; k++) begin
            i = k - first;
            check($sformatf("busy k=%0d", k), busy_out, (k < first + WORDS));
            check($sformatf("done k=%0d", k), done_out, (k == first + WORDS));
            check($sformatf("valid k=%0d", k), valid_out, (i >= 0 && i < WORDS));
            if (i >= 0 && i < WORDS) begin
                check($sformatf("n word %0d", i), n_out, vecs[i].n_exp);
                check($sformatf("m word %0d", i), m_out, vecs[i].m_exp);
                check($sformatf("last word %0d", i), last_out, vecs[i].last_exp);
            end else begin
                check($sformatf("n gated k=%0d", k), n_out, '0);
            end
            if (k == ready_low + 1) ready_in = 1'b1;
            if (inject && i == 10) begin
                start_in      = 1'b1;
                load_valid_in = 1'b1;
                load_addr_in  = ADDR_WIDTH'(5);
                load_data_in  = 32'hDEAD_BEEF;
            end else if (inject && i == 11) begin
                start_in      = 1'b0;
                load_valid_in = 1'b0;
            end
            tick();
        end
        xfer_id++;
        $display("transfer %0d: ready_low=%0d inject=%0d load_with_start=%0d new_errors=%0d",
                 xfer_id, ready_low, inject, load_with_start, miscompares - bad_before);
    endtask

    initial begin
        for (int w = 0; w < WORDS; w++) begin
            vecs[w].word     = w;
            vecs[w].n_exp    = RS'(w + 1);
            vecs[w].m_exp    = 32'hFFFF_FFFF - RS'(w);
            vecs[w].last_exp = (w == WORDS - 1);
        end

        rst_in        = 1'b1;
        load_data_in  = '0;
        load_addr_in  = '0;
        load_valid_in = 1'b0;
        start_in      = 1'b0;
        ready_in      = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_in = 1'b0;
        tick();
        check_idle_outputs("post-reset");

        for (int w = 0; w < WORDS; w++) begin
            load_word(w, vecs[w].n_exp);
            load_word(WORDS + w, vecs[w].m_exp);
        end
        tick();

        // Burst with ready already high, start/load pulsed mid-stream.
        transfer(0, 1'b1, 1'b0);
        // Ready held low for 50 cycles; word 5 must still be the original 6.
        transfer(50, 1'b0, 1'b0);

        // Reset while word 40 is on the outputs.
        start_in = 1'b1;
        ready_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int k = 1; k < 44; k++) tick();
        check("pre-reset n word 40", n_out, vecs[40].n_exp);
        check("pre-reset valid", valid_out, 1'b1);
        rst_in = 1'b1;
        tick();
        check_idle_outputs("mid-burst reset");
        rst_in = 1'b0;
        tick();
        transfer(0, 1'b0, 1'b0);

        // Same-cycle load of n word 0 and start.
        transfer(0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/bignum_operand_streamer.md
# bignum_operand_streamer

Transmitter for the block-serial big-number operand protocol: holds two BITS_IN_NUM-bit operands (n, m) in on-chip BRAM, and on command streams them out least-significant word first as a contiguous burst of REGISTER_SIZE-bit word pairs. It sits upstream of the block-serial multiplier and other arithmetic units that accept paired operand words. It waits for the consumer's ready, then emits exactly WORDS = BITS_IN_NUM/REGISTER_SIZE back-to-back valid cycles with no gaps. Operands persist after streaming, so the same pair can be re-sent.

## Interface
- REGISTER_SIZE, 32, word width in bits
- BITS_IN_NUM, 4096, operand width in bits; WORDS = BITS_IN_NUM/REGISTER_SIZE (128 by default)
- clk_in  input  1  single clock
- rst_in  input  1  synchronous, active-high reset
- load_data_in  input  REGISTER_SIZE  operand word to store
- load_addr_in  input  $clog2(2*WORDS)  word address: 0..WORDS-1 = n, WORDS..2*WORDS-1 = m
- load_valid_in  input  1  write strobe, accepted only in IDLE
- start_in  input  1  begin a transfer, accepted only in IDLE
- ready_in  input  1  consumer ready (the multiplier's ready_out)
- n_out  output  REGISTER_SIZE  n word; 0 when valid_out is low
- m_out  output  REGISTER_SIZE  m word; 0 when valid_out is low
- valid_out  output  1  word pair valid
- last_out  output  1  high with word WORDS-1 only
- busy_out  output  1  high in any state other than IDLE
- done_out  output  1  one-cycle pulse after the last word

## Operation
- States: IDLE, WAIT_READY, STREAM, DRAIN.
- IDLE: load_valid_in writes load_data_in to load_addr_in through BRAM port A. start_in moves the FSM to WAIT_READY.
- WAIT_READY: stays here while ready_in is low. When ready_in is sampled high, moves to STREAM with the read counter at 0.
- STREAM: each cycle presents n address k on port A and m address WORDS+k on port B, then increments k. After k = WORDS-1 is issued, moves to DRAIN. ready_in is ignored once STREAM is entered; the burst is never paused.
- DRAIN: waits for the 2-cycle read pipeline to empty. On the cycle after last_out, the FSM returns to IDLE and done_out pulses.
- A per-issue valid bit and last bit travel through a 2-stage pipe alongside the BRAM read latency. n_out and m_out are gated to 0 when that pipe is not valid.
- load_valid_in and start_in are ignored outside IDLE.
- load_valid_in and start_in in the same IDLE cycle: both are accepted. The write commits before the first read.
- Reset at any point: the FSM goes to IDLE and the pipes clear. BRAM contents are retained, not cleared.

## Timing
- Reset values: n_out=0, m_out=0, valid_out=0, last_out=0, busy_out=0, done_out=0.
- start_in is sampled at cycle S. busy_out is high from S+1.
- ready_in is sampled high in WAIT_READY at cycle T. Address 0 is issued at T+1.
- Word 0 appears on n_out/m_out with valid_out at T+3. Word i appears at T+3+i.
- last_out is high at T+2+WORDS, together with valid_out.
- done_out pulses at T+3+WORDS. busy_out is low from that same cycle.
- Fastest restart: start_in in the done_out cycle is accepted, because the FSM is already in IDLE.
- Width rules: the address counter is $clog2(WORDS)+1 bits, and the m address is computed as WORDS+k with no wrap. load_addr_in wraps naturally modulo 2*WORDS.
- When ready_in is already high at start: S+1 is in WAIT_READY and T = S+1, so first valid_out is at S+4.

## Structure
- Shared package holds:
  - the REGISTER_SIZE and BITS_IN_NUM defaults;
  - the derived WORDS and ADDR_WIDTH;
  - the operand-streamer state enum, also used by the consumer-side testbench monitors.
- One sub-module: xilinx_true_dual_port_read_first_2_clock_ram, with RAM_WIDTH=REGISTER_SIZE and RAM_DEPTH=2*WORDS, clocked on clk_in.
  - Port A: write in IDLE, read n.
  - Port B: read-only, m.
  - regce is held high during STREAM/DRAIN.
- Remaining logic is the FSM, counter, 2-stage valid/last pipe and output gating. Target size is about 150-250 lines.

## Test plan
- Load n word i = i+1 and m word i = 0xFFFF_FFFF-i for i=0..127, start with ready high -> 128 consecutive valid cycles, word i matches, first valid at start+4, last_out on word 127, done_out the next cycle.
- Start with ready_in held low for 50 cycles -> busy_out high, valid_out low throughout. ready_in raised at T -> first valid at T+3.
- Pulse start_in and load_valid_in (addr 5, data 0xDEAD_BEEF) mid-stream -> both ignored: burst unchanged, n word 5 still equals 6 on the next transfer.
- Assert rst_in during word 40 -> next cycle all outputs 0, busy_out 0. A new start re-streams from word 0 with the original stored values.
- Drive the multiplier with n=3, m=5 (all other words 0) -> multiplier result word 0 = 15, words 1..255 = 0, exactly one operand burst observed.
- Same-cycle load and start in IDLE (addr 0, data 0x1234) -> the streamed n word 0 = 0x1234.
